// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory controller.
// Size codes, FSM states and the bus timeout default live here.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } stateT;

  // Reserved size 2'b11 falls through to the word case in every helper.
  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    isAligned = 1'b1;
      SZ_H:    isAligned = ~lane[0];
      default: isAligned = (lane == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] laneEnables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    laneEnables = 4'b0001 << lane;
      SZ_H:    laneEnables = 4'b0011 << lane;
      default: laneEnables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_B:    laneData = {4{wd[7:0]}};
      SZ_H:    laneData = {2{wd[15:0]}};
      default: laneData = wd;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_ld_extend.sv
// Load alignment: moves the addressed byte/half down to bit 0 and
// sign- or zero-extends it; word loads pass through untouched.
module ld_extend
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        isSigned,
  output logic [31:0] extData
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    case (size)
      SZ_B:    extData = {{24{isSigned & shifted[7]}}, shifted[7:0]};
      SZ_H:    extData = {{16{isSigned & shifted[15]}}, shifted[15:0]};
      default: extData = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller: sizes and places store data, checks alignment,
// runs one req/ack bus transaction per access and stalls the pipeline meanwhile.
// Handshake: bus_req stays high with stable bus_we/addr/be/wdata until the first
// cycle bus_ack is high; bus_rdata/bus_err are sampled only in that cycle.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memen,
  input  logic        memwrite,
  input  logic [1:0]  memsize,
  input  logic        memsigned,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        adel,
  output logic        ades,
  output logic        buserr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic [1:0]  dbgState
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  stateT         state;
  logic [CW-1:0] cnt;
  logic          weR;
  logic [29:0]   addrR;
  logic [3:0]    beR;
  logic [31:0]   wdataR;
  logic [1:0]    sizeR;
  logic          signedR;
  logic [1:0]    laneR;
  logic          errR;

  logic          aligned;
  logic          idleReq;
  logic [31:0]   extData;

  assign aligned = isAligned(memsize, addr[1:0]);
  assign idleReq = (state == IDLE) && memen;

  // Misaligned requests never leave IDLE, so they raise the error pulse and no stall.
  assign stall = (idleReq && aligned) || (state == BUSY);
  assign adel  = idleReq && !aligned && !memwrite;
  assign ades  = idleReq && !aligned && memwrite;

  assign bus_req   = (state == BUSY);
  assign bus_we    = bus_req && weR;
  assign bus_addr  = bus_req ? {addrR, 2'b00} : 32'h0;
  assign bus_be    = bus_req ? beR : 4'h0;
  assign bus_wdata = bus_req ? wdataR : 32'h0;

  assign buserr   = (state == RESP) && errR;
  assign dbgState = state;

  ld_extend u_ldExtend (
    .rdata    (bus_rdata),
    .lane     (laneR),
    .size     (sizeR),
    .isSigned (signedR),
    .extData  (extData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      weR      <= 1'b0;
      addrR    <= '0;
      beR      <= '0;
      wdataR   <= '0;
      sizeR    <= SZ_B;
      signedR  <= 1'b0;
      laneR    <= '0;
      errR     <= 1'b0;
      readdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memen && aligned) begin
            weR     <= memwrite;
            addrR   <= addr[31:2];
            beR     <= laneEnables(memsize, addr[1:0]);
            wdataR  <= laneData(memsize, writedata);
            sizeR   <= memsize;
            signedR <= memsigned;
            laneR   <= addr[1:0];
            errR    <= 1'b0;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // readdata is loaded on the way into RESP so the pipeline sees it
          // in the same cycle stall drops.
          if (bus_ack) begin
            errR  <= bus_err;
            if (!weR) readdata <= bus_err ? 32'h0 : extData;
            cnt   <= '0;
            state <= RESP;
          end else if (cnt == CNT_LAST) begin
            errR  <= 1'b1;
            if (!weR) readdata <= 32'h0;
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
